// File: rtl/wb_regfile.sv
// Write-back register file: 8x16 GPRs with R7 aliased to the PC, C/Z flags, redirect on R7 write-back,
// and a per-register pending-write scoreboard. Define FWD_BYPASS_EN to forward the retiring value to the read ports.
module wb_regfile #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int PC_REG = 7,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reg_write,
  input  logic [2:0]        wr_add,
  input  logic [1:0]        m3,
  input  logic [DATA_W-1:0] alu_res,
  input  logic [DATA_W-1:0] mem_rd_data,
  input  logic [DATA_W-1:0] shift,
  input  logic [DATA_W-1:0] pc_p1,
  input  logic              c_flag,
  input  logic              z_flag,
  input  logic              flag_wr,
  input  logic              pc_wr_en,
  input  logic [DATA_W-1:0] pc_next,
  input  logic [2:0]        rd_add1,
  input  logic [2:0]        rd_add2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              busy1,
  output logic              busy2,
  input  logic              issue_en,
  input  logic [2:0]        issue_add,
  output logic [DATA_W-1:0] r7_out,
  output logic              c_out,
  output logic              z_out,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              sb_err
);

  localparam logic [2:0] PC_ADDR = 3'(PC_REG);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic [CNT_W-1:0]  cnt_q  [NREG];
  logic [CNT_W-1:0]  cnt_d  [NREG];
  logic              c_q, c_d, z_q, z_d;
  logic              redirect_q, redirect_d;
  logic              sb_err_q, sb_err_d;
  logic [DATA_W-1:0] rpc_q, rpc_d;
  logic [DATA_W-1:0] wb_data;
  logic [NREG-1:0]   inc, dec;

  always_comb begin
    unique case (m3)
      2'b00:   wb_data = alu_res;
      2'b01:   wb_data = mem_rd_data;
      2'b10:   wb_data = shift;
      default: wb_data = pc_p1;
    endcase
  end

  always_comb begin
    inc = '0;
    dec = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      inc[i] = issue_en  && (issue_add == i[2:0]);
      dec[i] = reg_write && (wr_add    == i[2:0]);
    end
  end

  always_comb begin
    regs_d   = regs_q;
    cnt_d    = cnt_q;
    c_d      = c_q;
    z_d      = z_q;
    sb_err_d = sb_err_q;
    // Write-back is applied after the fetch update so it wins on R7.
    if (pc_wr_en)  regs_d[PC_REG] = pc_next;
    if (reg_write) regs_d[wr_add] = wb_data;
    redirect_d = reg_write && (wr_add == PC_ADDR);
    rpc_d      = redirect_d ? wb_data : rpc_q;
    if (flag_wr) begin
      c_d = c_flag;
      z_d = z_flag;
    end
    for (int unsigned i = 0; i < NREG; i++) begin
      unique case ({inc[i], dec[i]})
        2'b10: begin
          if (cnt_q[i] == '1) sb_err_d = 1'b1;
          else                cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        2'b01: begin
          if (cnt_q[i] == '0) sb_err_d = 1'b1;
          else                cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        cnt_q[i]  <= '0;
      end
      c_q        <= 1'b0;
      z_q        <= 1'b0;
      redirect_q <= 1'b0;
      rpc_q      <= '0;
      sb_err_q   <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      cnt_q      <= cnt_d;
      c_q        <= c_d;
      z_q        <= z_d;
      redirect_q <= redirect_d;
      rpc_q      <= rpc_d;
      sb_err_q   <= sb_err_d;
    end
  end

`ifdef FWD_BYPASS_EN
  logic hit1, hit2;
  // Forwarding is suppressed during reset so every output reads zero.
  assign hit1     = rst && reg_write && (wr_add == rd_add1);
  assign hit2     = rst && reg_write && (wr_add == rd_add2);
  assign rd_data1 = hit1 ? wb_data : regs_q[rd_add1];
  assign rd_data2 = hit2 ? wb_data : regs_q[rd_add2];
  assign busy1    = (cnt_q[rd_add1] != '0) && !(hit1 && (cnt_q[rd_add1] == CNT_W'(1)));
  assign busy2    = (cnt_q[rd_add2] != '0) && !(hit2 && (cnt_q[rd_add2] == CNT_W'(1)));
`else
  assign rd_data1 = regs_q[rd_add1];
  assign rd_data2 = regs_q[rd_add2];
  assign busy1    = (cnt_q[rd_add1] != '0);
  assign busy2    = (cnt_q[rd_add2] != '0);
`endif

  assign r7_out      = regs_q[PC_REG];
  assign c_out       = c_q;
  assign z_out       = z_q;
  assign redirect    = redirect_q;
  assign redirect_pc = rpc_q;
  assign sb_err      = sb_err_q;

endmodule
